// File: rtl/final_layer_loader.sv
// final_layer_loader
// Producer side of the final-layer classifier interface. A narrow LSB-first
// byte stream is deserialised in place into one activation vector followed
// by NUM_NEURONS weight vectors. A one-cycle out_valid pulse marks a complete
// frame. A held weight set can be reused so later frames carry activations only.
module final_layer_loader #(
    parameter int NUM_INPUTS  = 196,
    parameter int NUM_NEURONS = 10,
    parameter int BUS_W       = 8
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [BUS_W-1:0]                        in_data,
    input  logic                                    keep_weights,
    input  logic                                    frame_abort,
    output logic [NUM_INPUTS-1:0]                   data_out,
    output logic [NUM_NEURONS-1:0][NUM_INPUTS-1:0]  weights_out,
    output logic                                    weights_held,
    output logic                                    out_valid
);

    localparam int BEATS  = (NUM_INPUTS + BUS_W - 1) / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NEUR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [NEUR_W-1:0] LAST_NEURON = NEUR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        LOAD_DATA    = 2'd0,
        LOAD_WEIGHTS = 2'd1,
        DONE         = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [BEAT_W-1:0]                      beat_cnt_q, beat_cnt_d;
    logic [NEUR_W-1:0]                      neuron_cnt_q, neuron_cnt_d;
    logic                                   held_q, held_d;
    logic [NUM_INPUTS-1:0]                  data_q, data_d;
    logic [NUM_NEURONS-1:0][NUM_INPUTS-1:0] weights_q, weights_d;

    logic                                   xfer;
    logic                                   wr_data;
    logic                                   wr_weights;
    logic [BEATS-1:0]                       beat_sel;
    logic [NUM_NEURONS-1:0]                 neuron_sel;

    // Ready is withheld during the DONE cycle and while reset is asserted,
    // so no beat can land on the vectors while a finished frame is presented.
    assign in_ready = (state_q != DONE) && !reset;
    assign xfer     = in_valid && in_ready;

    // Control state: FSM, beat/neuron counters and the held flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LOAD_DATA;
            beat_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            held_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            neuron_cnt_q <= neuron_cnt_d;
            held_q       <= held_d;
        end
    end

    // Next-state logic; abort overrides any transfer in the same cycle.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        neuron_cnt_d = neuron_cnt_q;
        held_d       = held_q;
        wr_data      = 1'b0;
        wr_weights   = 1'b0;

        if (frame_abort) begin
            state_d      = LOAD_DATA;
            beat_cnt_d   = '0;
            neuron_cnt_d = '0;
            // A partially rewritten weight set must never look valid.
            if (state_q == LOAD_WEIGHTS) begin
                held_d = 1'b0;
            end
        end else begin
            case (state_q)
                LOAD_DATA: begin
                    if (xfer) begin
                        wr_data = 1'b1;
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_d   = '0;
                            neuron_cnt_d = '0;
                            if (keep_weights && held_q) begin
                                state_d = DONE;
                            end else begin
                                state_d = LOAD_WEIGHTS;
                                held_d  = 1'b0;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                LOAD_WEIGHTS: begin
                    if (xfer) begin
                        wr_weights = 1'b1;
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_d = '0;
                            if (neuron_cnt_q == LAST_NEURON) begin
                                neuron_cnt_d = '0;
                                held_d       = 1'b1;
                                state_d      = DONE;
                            end else begin
                                neuron_cnt_d = neuron_cnt_q + NEUR_W'(1);
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d      = LOAD_DATA;
                    beat_cnt_d   = '0;
                    neuron_cnt_d = '0;
                end
                default: begin
                    state_d      = LOAD_DATA;
                    beat_cnt_d   = '0;
                    neuron_cnt_d = '0;
                end
            endcase
        end
    end

    // One-hot decode of the current beat and neuron position.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat_sel
            assign beat_sel[gi] = (beat_cnt_q == BEAT_W'(gi));
        end
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron_sel
            assign neuron_sel[gi] = (neuron_cnt_q == NEUR_W'(gi));
        end
    endgenerate

    // Per-bit in-place write: vector bit i belongs to beat i/BUS_W, lane
    // i%BUS_W. Lanes of the final beat beyond NUM_INPUTS have no home and
    // are simply dropped.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_data_bit
            assign data_d[gi] = (wr_data && beat_sel[gi / BUS_W])
                              ? in_data[gi % BUS_W] : data_q[gi];
        end
        for (genvar ni = 0; ni < NUM_NEURONS; ni++) begin : g_neuron
            for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_weight_bit
                assign weights_d[ni][gi] =
                    (wr_weights && neuron_sel[ni] && beat_sel[gi / BUS_W])
                    ? in_data[gi % BUS_W] : weights_q[ni][gi];
            end
        end
    endgenerate

    // Vector storage; untouched bits hold, so outputs stay stable between writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q    <= '0;
            weights_q <= '0;
        end else begin
            data_q    <= data_d;
            weights_q <= weights_d;
        end
    end

    assign data_out     = data_q;
    assign weights_out  = weights_q;
    assign weights_held = held_q;
    assign out_valid    = (state_q == DONE);

endmodule

// File: tb/tb_final_layer_loader.sv
// Testbench for final_layer_loader: frame-level reference model driven by
// the same stimulus, with per-cycle handshake/pulse checks and per-frame
// vector checks.
module tb_final_layer_loader;

    localparam int NI    = 196;
    localparam int NN    = 10;
    localparam int BW    = 8;
    localparam int BEATS = (NI + BW - 1) / BW;
    localparam int FRAME = BEATS * (NN + 1);

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [BW-1:0]          in_data;
    logic                   keep_weights;
    logic                   frame_abort;
    logic [NI-1:0]          data_out;
    logic [NN-1:0][NI-1:0]  weights_out;
    logic                   weights_held;
    logic                   out_valid;

    final_layer_loader #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .BUS_W(BW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .keep_weights (keep_weights),
        .frame_abort  (frame_abort),
        .data_out     (data_out),
        .weights_out  (weights_out),
        .weights_held (weights_held),
        .out_valid    (out_valid)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: position in frame, held flag, completion flag, vectors.
    int            m_pos;
    bit            m_held;
    bit            m_done;
    logic [NI-1:0] m_data;
    logic [NI-1:0] m_w [NN];
    logic [BW-1:0] beats [FRAME];
    int            dut_beats;
    int            ov_count;

    task automatic check_eq(string tag, logic [255:0] obs, logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_held = 1'b0;
        m_done = 1'b0;
        m_data = '0;
        for (int n = 0; n < NN; n++) m_w[n] = '0;
    endtask

    // Beat number p of a frame fills vector p/BEATS (0 = activations),
    // bits (p%BEATS)*BW .. +BW-1, dropping bits past NI.
    task automatic model_write(int pos, logic [BW-1:0] d);
        int v = pos / BEATS;
        int b = pos % BEATS;
        for (int j = 0; j < BW; j++) begin
            if (b * BW + j < NI) begin
                if (v == 0) m_data[b * BW + j] = d[j];
                else        m_w[v - 1][b * BW + j] = d[j];
            end
        end
    endtask

    task automatic model_clock(bit v, logic [BW-1:0] d, bit keep, bit abort);
        if (abort) begin
            if (m_pos >= BEATS) m_held = 1'b0;
            m_pos  = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (v) begin
            model_write(m_pos, d);
            m_pos++;
            if (m_pos == BEATS && keep && m_held) begin
                m_pos  = 0;
                m_done = 1'b1;
            end else if (m_pos == BEATS) begin
                m_held = 1'b0;
            end else if (m_pos == FRAME) begin
                m_pos  = 0;
                m_held = 1'b1;
                m_done = 1'b1;
            end
        end
    endtask

    // One clock: drive, check ready, clock, advance model, check pulse/held.
    task automatic tick(bit v, logic [BW-1:0] d, bit keep, bit abort);
        in_valid     = v;
        in_data      = d;
        keep_weights = keep;
        frame_abort  = abort;
        #1;
        check_eq("in_ready", in_ready, !m_done);
        if (v && in_ready && !abort) dut_beats++;
        @(posedge clock);
        model_clock(v, d, keep, abort);
        #1;
        check_eq("out_valid", out_valid, m_done);
        check_eq("weights_held", weights_held, m_held);
        if (out_valid) ov_count++;
    endtask

    task automatic check_vectors(string tag);
        check_eq({tag, "_data"}, data_out, m_data);
        for (int n = 0; n < NN; n++)
            check_eq($sformatf("%s_w%0d", tag, n), weights_out[n], m_w[n]);
    endtask

    task automatic do_reset(int n);
        reset       = 1'b1;
        in_valid    = 1'b0;
        frame_abort = 1'b0;
        keep_weights = 1'b0;
        in_data     = '0;
        repeat (n) @(posedge clock);
        #1;
        model_reset();
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_held", weights_held, 1'b0);
        check_vectors("rst");
        reset = 1'b0;
        #1;
        check_eq("ready_after_reset", in_ready, 1'b1);
    endtask

    task automatic fill_std();
        for (int p = 0; p < FRAME; p++) begin
            if (p < BEATS) beats[p] = 8'hFF;
            else beats[p] = (((p - BEATS) / BEATS) % 2 == 1) ? 8'hA5 : 8'h00;
        end
    endtask

    task automatic fill_rand();
        for (int p = 0; p < FRAME; p++) beats[p] = BW'($urandom);
    endtask

    // Stream one frame from beats[]; abort_at < 0 means no abort.
    task automatic run_frame(string tag, bit keep, int gap_pct, int abort_at, int exp_beats);
        int guard = 0;
        bit fin   = 1'b0;
        dut_beats = 0;
        ov_count  = 0;
        while (!fin && guard < 3000) begin
            bit v  = ($urandom_range(99) >= gap_pct);
            bit ab = 1'b0;
            if (abort_at >= 0 && m_pos == abort_at) begin
                v  = 1'b1;
                ab = 1'b1;
            end
            tick(v, beats[m_pos], keep, ab);
            guard++;
            if (ab || m_done) fin = 1'b1;
        end
        if (guard >= 3000) check_eq({tag, "_timeout"}, 1'b1, 1'b0);
        if (abort_at < 0) begin
            check_eq({tag, "_beats"}, dut_beats, exp_beats);
            check_vectors({tag, "_done"});
            // Offer a beat during DONE: it must not be taken.
            tick(1'b1, 8'h3C, keep, 1'b0);
            check_vectors({tag, "_after"});
            check_eq({tag, "_pulses"}, ov_count, 1);
        end else begin
            repeat (3) tick(1'b0, 8'h00, keep, 1'b0);
            check_eq({tag, "_abort_pulses"}, ov_count, 0);
            check_eq({tag, "_abort_held"}, weights_held, m_held);
        end
        $display("frame %s: beats=%0d pulses=%0d held=%0b", tag, dut_beats, ov_count, weights_held);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        keep_weights = 1'b0;
        frame_abort = 1'b0;

        // Reset behaviour.
        do_reset(3);

        // Back-to-back standard frame.
        fill_std();
        run_frame("t2", 1'b0, 0, -1, FRAME);
        check_eq("t2_data_ones", data_out, {NI{1'b1}});
        check_eq("t2_w1_lo", weights_out[1][7:0], 8'hA5);
        check_eq("t2_w1_hi", weights_out[1][195:192], 4'h5);
        check_eq("t2_w0", weights_out[0], '0);
        check_eq("t2_held", weights_held, 1'b1);

        // Same frame with random gaps (final data beat 8'hFF, upper lanes dropped).
        run_frame("t3", 1'b0, 35, -1, FRAME);
        check_eq("t3_data_ones", data_out, {NI{1'b1}});

        // Weights reused: activations only.
        for (int p = 0; p < BEATS; p++) beats[p] = 8'h0F;
        run_frame("t4a", 1'b1, 0, -1, BEATS);
        check_eq("t4_data_lo", data_out[7:0], 8'h0F);
        check_eq("t4_w1_lo", weights_out[1][7:0], 8'hA5);

        // After reset keep_weights has nothing to reuse.
        do_reset(2);
        fill_std();
        run_frame("t4b", 1'b1, 0, -1, FRAME);

        // Abort at neuron 4 beat 10, then a keep frame needs all beats.
        fill_rand();
        run_frame("t5a", 1'b0, 0, BEATS + 4 * BEATS + 10, 0);
        check_eq("t5_held", weights_held, 1'b0);
        fill_std();
        run_frame("t5b", 1'b1, 0, -1, FRAME);

        // Reset in the middle of the activation phase.
        for (int p = 0; p < 12; p++) tick(1'b1, 8'h77, 1'b0, 1'b0);
        do_reset(1);
        fill_std();
        run_frame("t6", 1'b0, 0, -1, FRAME);

        // Randomised frames.
        for (int f = 0; f < 5; f++) begin
            bit k = 1'($urandom_range(1));
            fill_rand();
            if (f == 2) begin
                run_frame($sformatf("r%0d", f), 1'b0, 20, int'($urandom_range(FRAME - 1)), 0);
            end else begin
                run_frame($sformatf("r%0d", f), k, 20, -1, (k && m_held) ? BEATS : FRAME);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
